// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue stage: FSM codes and ALU opcodes.
package alu_issue_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t EXEC = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_NOT = 4'b0100;

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Register file: async reset, two operand reads, one debug read,
// one synchronous write. R0 is never written, so it always reads 0.
module alu_issue_ctrl_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int N = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [N];
  logic [DATA_W-1:0] mem_d [N];

  always_comb begin
    mem_d = mem_q;
    if (we && (wa != '0)) begin
      mem_d[wa] = wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign ra_data  = mem_q[ra_addr];
  assign rb_data  = mem_q[rb_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the combinational ALU: accept, drive operands,
// capture the result one edge later and write it back.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_imm_en,
  input  logic [DATA_W-1:0] in_imm,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_carry,
  output logic [ADDR_W-1:0] out_rd,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              carry_q, carry_d;
  logic [ADDR_W-1:0] ord_q, ord_d;

  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              wb_en;

  alu_issue_ctrl_regfile #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (in_rs),
    .ra_data (rs_data),
    .rb_addr (in_rt),
    .rb_data (rt_data),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .we      (wb_en),
    .wa      (rd_q),
    .wd      (alu_out)
  );

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    x_d     = x_q;
    y_d     = y_q;
    rd_d    = rd_q;
    vld_d   = vld_q;
    data_d  = data_q;
    carry_d = carry_q;
    ord_d   = ord_q;
    wb_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ctrl_d  = in_ctrl;
          x_d     = rs_data;
          y_d     = in_imm_en ? in_imm : rt_data;
          rd_d    = in_rd;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d  = alu_out;
        carry_d = alu_carry;
        ord_d   = rd_q;
        vld_d   = 1'b1;
        wb_en   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rd_q    <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      carry_q <= 1'b0;
      ord_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rd_q    <= rd_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      ord_q   <= ord_d;
    end
  end

  assign alu_ctrl  = ctrl_q;
  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_carry = carry_q;
  assign out_rd    = ord_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU
// attached to its alu_* ports.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_ctrl = '0;
  logic [2:0] in_rs = '0;
  logic [2:0] in_rt = '0;
  logic [2:0] in_rd = '0;
  logic       in_imm_en = 1'b0;
  logic [7:0] in_imm = '0;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_x;
  logic [7:0] alu_y;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_carry;
  logic [2:0] out_rd;
  logic [2:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_rs    (in_rs),
    .in_rt    (in_rt),
    .in_rd    (in_rd),
    .in_imm_en(in_imm_en),
    .in_imm   (in_imm),
    .alu_ctrl (alu_ctrl),
    .alu_x    (alu_x),
    .alu_y    (alu_y),
    .alu_out  (alu_out),
    .alu_carry(alu_carry),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_carry(out_carry),
    .out_rd   (out_rd),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Reference ALU: only the opcodes exercised here
  logic [8:0] sum;
  always_comb begin
    sum       = {1'b0, alu_x} + {1'b0, alu_y};
    alu_out   = 8'h00;
    alu_carry = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        alu_out   = sum[7:0];
        alu_carry = sum[8];
      end
      OP_NOT: alu_out = ~alu_x;
      default: alu_out = alu_x & alu_y;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string nm, input logic [3:0] c,
                       input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] rd, input logic ie,
                       input logic [7:0] imm, input logic [7:0] e_data,
                       input logic e_carry, input logic [7:0] e_reg);
    int w;
    w = 0;
    while (!in_ready && w < 10) begin
      step();
      w++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_timeout got=%b want=1", nm, in_ready);
    end
    in_ctrl = c; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm_en = ie; in_imm = imm; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s exec got vld=%b rdy=%b want 0/0", nm, out_valid, in_ready);
    end
    step();
    dbg_addr = rd;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== e_data ||
        out_carry !== e_carry || out_rd !== rd) begin
      n_bad++;
      $display("FAIL %s result got v=%b d=%h c=%b rd=%0d want 1 %h %b %0d",
               nm, out_valid, out_data, out_carry, out_rd, e_data, e_carry, rd);
    end
    n_cmp++;
    if (dbg_data !== e_reg) begin
      n_bad++;
      $display("FAIL %s regfile got=%h want=%h", nm, dbg_data, e_reg);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== e_data) begin
      n_bad++;
      $display("FAIL %s done got vld=%b rdy=%b d=%h want 0 1 %h",
               nm, out_valid, in_ready, out_data, e_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || alu_x !== 8'h00 ||
        alu_y !== 8'h00 || alu_ctrl !== 4'h0 || out_rd !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_outs got v=%b d=%h x=%h y=%h c=%h rd=%0d want zeros",
               out_valid, out_data, alu_x, alu_y, alu_ctrl, out_rd);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready got=%b want=1", in_ready);
    end
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a);
      #1;
      n_cmp++;
      if (dbg_data !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_reg%0d got=%h want=00", a, dbg_data);
      end
    end
  endtask

  task automatic test_imm_not();
    do_op("add_imm", OP_ADD, 3'd0, 3'd7, 3'd1, 1'b1, 8'h05, 8'h05, 1'b0, 8'h05);
    do_op("not_r1", OP_NOT, 3'd1, 3'd0, 3'd2, 1'b0, 8'h00, 8'hFA, 1'b0, 8'hFA);
  endtask

  task automatic test_back_to_back();
    do_op("dep1", OP_ADD, 3'd1, 3'd1, 3'd1, 1'b0, 8'h00, 8'h0A, 1'b0, 8'h0A);
    do_op("dep2", OP_ADD, 3'd1, 3'd1, 3'd1, 1'b0, 8'h00, 8'h14, 1'b0, 8'h14);
  endtask

  task automatic test_carry();
    do_op("carry", OP_ADD, 3'd2, 3'd0, 3'd3, 1'b1, 8'h10, 8'h0A, 1'b1, 8'h0A);
  endtask

  task automatic test_r0();
    do_op("r0_not", OP_NOT, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b0, 8'h00);
  endtask

  task automatic test_busy();
    logic [5:0] e_rdy;
    logic [5:0] e_vld;
    int pulses;
    e_rdy  = 6'b110010;
    e_vld  = 6'b001001;
    pulses = 0;
    in_ctrl = OP_ADD; in_rs = 3'd1; in_rd = 3'd4;
    in_imm_en = 1'b1; in_imm = 8'h01; in_valid = 1'b1;
    step();
    in_ctrl = OP_NOT; in_rs = 3'd1; in_rd = 3'd5; in_imm_en = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 3) in_valid = 1'b0;
      if (out_valid === 1'b1) pulses++;
      n_cmp++;
      if (in_ready !== e_rdy[k-1] || out_valid !== e_vld[k-1]) begin
        n_bad++;
        $display("FAIL busy_k%0d got rdy=%b vld=%b want %b %b",
                 k, in_ready, out_valid, e_rdy[k-1], e_vld[k-1]);
      end
      if (k == 1) begin
        n_cmp++;
        if (out_data !== 8'h15 || out_rd !== 3'd4) begin
          n_bad++;
          $display("FAIL busy_opA got d=%h rd=%0d want 15 4", out_data, out_rd);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if (out_data !== 8'hEB || out_rd !== 3'd5) begin
          n_bad++;
          $display("FAIL busy_opB got d=%h rd=%0d want EB 5", out_data, out_rd);
        end
      end
    end
    n_cmp++;
    if (pulses != 2) begin
      n_bad++;
      $display("FAIL busy_pulses got=%0d want=2", pulses);
    end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    pulses = 0;
    in_ctrl = OP_ADD; in_rs = 3'd1; in_rd = 3'd6;
    in_imm_en = 1'b1; in_imm = 8'h33; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_async got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (out_valid === 1'b1) pulses++;
    end
    dbg_addr = 3'd6;
    #1;
    n_cmp++;
    if (pulses != 0 || dbg_data !== 8'h00 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_after got pulses=%0d r6=%h rdy=%b want 0 00 1",
               pulses, dbg_data, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_imm_not();
    test_back_to_back();
    test_carry();
    test_r0();
    test_busy();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
